// File: rtl/shared_incr_pkg.sv
// Shared definitions for the time-shared incrementer scheduler:
// FSM state encoding and default geometry.
package shared_incr_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OPERAND = 2'd1,
    S_WRITE   = 2'd2
  } state_t;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_WIDTH    = 8;

endpackage

// File: rtl/shared_incrementer_scheduler_ripple_incrementer.sv
// Combinational ripple incrementer: a chain of half-adder cells with the
// carry into bit 0 tied high, producing a + 1 and the carry-out.
module ripple_incrementer #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ha
      assign o_sum[gi]       = i_a[gi] ^ w_carry[gi];
      assign w_carry[gi + 1] = i_a[gi] & w_carry[gi];
    end
  endgenerate

  assign o_cout = w_carry[WIDTH];

endmodule

// File: rtl/shared_incrementer_scheduler.sv
// Round-robin scheduler that time-shares one registered incrementer among
// CHANNELS counters: grant in S_IDLE, compute in S_OPERAND, ack/write in S_WRITE.
module shared_incrementer_scheduler
  import shared_incr_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH
) (
  input  logic                      i_clk,
  input  logic                      i_RESET_n,
  input  logic [CHANNELS-1:0]       i_req,
  input  logic [CHANNELS-1:0]       i_clr,
  output logic [CHANNELS-1:0]       o_ack,
  output logic [CHANNELS*WIDTH-1:0] o_count,
  output logic                      o_wrap,
  output logic                      o_busy
);

  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_t           r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_idx;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH:0]   r_result;
  logic             r_kill;

  logic [WIDTH-1:0] w_count [CHANNELS];
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_grant_valid;
  logic [PW-1:0]    w_grant_idx;
  logic [PW-1:0]    w_cand;

  ripple_incrementer #(.WIDTH(WIDTH)) u_incr (
    .i_a    (r_operand),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Scan offsets from farthest to nearest so the first requester at or
  // after the pointer is the last one written and therefore wins.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      w_cand = PW'((int'(r_ptr) + i) % CHANNELS);
      if (i_req[w_cand]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = w_cand;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_operand <= '0;
      r_result  <= '0;
      r_kill    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_valid) begin
            r_idx     <= w_grant_idx;
            r_operand <= w_count[w_grant_idx];
            r_kill    <= 1'b0;
            r_state   <= S_OPERAND;
          end
        end
        S_OPERAND: begin
          r_result <= {w_cout, w_sum};
          // A clear of the in-flight channel here cancels write-back and wrap.
          r_kill   <= i_clr[r_idx];
          r_state  <= S_WRITE;
        end
        S_WRITE: begin
          r_ptr   <= (r_idx == PW'(CHANNELS - 1)) ? '0 : r_idx + PW'(1);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] r_cnt;

      assign o_ack[gi] = (r_state == S_WRITE) && (r_idx == PW'(gi));

      always_ff @(posedge i_clk or negedge i_RESET_n) begin
        if (!i_RESET_n)
          r_cnt <= '0;
        else if (i_clr[gi])
          r_cnt <= '0;
        else if (o_ack[gi] && !r_kill)
          r_cnt <= r_result[WIDTH-1:0];
      end

      assign w_count[gi]                = r_cnt;
      assign o_count[gi*WIDTH +: WIDTH] = r_cnt;
    end
  endgenerate

  assign o_busy = (r_state != S_IDLE);
  assign o_wrap = (r_state == S_WRITE) && r_result[WIDTH] && !r_kill;

endmodule

// File: tb/tb_shared_incrementer_scheduler.sv
// Directed bench for the shared incrementer scheduler: a cycle table for the
// round-robin sequence plus hand-written wrap, clear, reset and withdraw cases.
module tb_shared_incrementer_scheduler;

  localparam int CH = 4;
  localparam int W  = 8;

  logic            i_clk = 1'b0;
  logic            i_RESET_n;
  logic [CH-1:0]   i_req;
  logic [CH-1:0]   i_clr;
  logic [CH-1:0]   o_ack;
  logic [CH*W-1:0] o_count;
  logic            o_wrap;
  logic            o_busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [CH-1:0] req;
    logic [CH-1:0] clr;
    logic [CH-1:0] ack;
    logic          wrap;
    logic          busy;
    logic          use_count;
    logic [31:0]   count;
  } vec_t;

  vec_t tbl [26];

  shared_incrementer_scheduler #(.CHANNELS(CH), .WIDTH(W)) dut (
    .i_clk     (i_clk),
    .i_RESET_n (i_RESET_n),
    .i_req     (i_req),
    .i_clr     (i_clr),
    .o_ack     (o_ack),
    .o_count   (o_count),
    .o_wrap    (o_wrap),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] cnt(input int k);
    return o_count[k*W +: W];
  endfunction

  task automatic do_reset();
    i_RESET_n = 1'b0;
    i_req     = '0;
    i_clr     = '0;
    repeat (2) @(negedge i_clk);
    i_RESET_n = 1'b1;
  endtask

  // One full request/ack handshake on channel ch; returns in the following S_IDLE.
  task automatic incr(input int ch, output logic [CH-1:0] ack_v, output logic wrap_v);
    logic got;
    got    = 1'b0;
    ack_v  = '0;
    wrap_v = 1'b0;
    i_req[ch] = 1'b1;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge i_clk);
      if (o_ack != '0) begin
        got    = 1'b1;
        ack_v  = o_ack;
        wrap_v = o_wrap;
      end
    end
    i_req[ch] = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: got no ack want ack on channel %0d", ch);
    end
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH-1:0] a;
    logic          wr;

    // Fairness rows: each operation is grant->S_OPERAND, S_WRITE (ack), S_IDLE.
    for (int k = 0; k < 8; k++) begin
      tbl[3*k]   = '{4'b1111, 4'b0000, 4'b0000,       1'b0, 1'b1, 1'b0, 32'h0};
      tbl[3*k+1] = '{4'b1111, 4'b0000, 4'(1 << (k%4)), 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[3*k+2] = '{4'b1111, 4'b0000, 4'b0000,       1'b0, 1'b0, 1'b0, 32'h0};
    end
    tbl[23].use_count = 1'b1;
    tbl[23].count     = 32'h02020202;
    tbl[24] = '{4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h02020200};
    tbl[25] = '{4'b0000, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h00020000};

    i_req     = '0;
    i_clr     = '0;
    i_RESET_n = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("reset_busy",  o_busy,  0);
    chk("reset_ack",   o_ack,   0);
    chk("reset_wrap",  o_wrap,  0);
    chk("reset_count", o_count, 0);
    i_RESET_n = 1'b1;

    // Single request on channel 0.
    i_req = 4'b0001;
    @(negedge i_clk);
    chk("single_operand_busy", o_busy, 1);
    chk("single_operand_ack",  o_ack,  0);
    @(negedge i_clk);
    chk("single_write_ack",  o_ack,  4'b0001);
    chk("single_write_busy", o_busy, 1);
    i_req = '0;
    @(negedge i_clk);
    chk("single_idle_busy", o_busy,  0);
    chk("single_count",     o_count, 32'h00000001);

    // Round-robin table.
    do_reset();
    for (int r = 0; r < 26; r++) begin
      i_req = tbl[r].req;
      i_clr = tbl[r].clr;
      @(negedge i_clk);
      chk($sformatf("tbl%0d_ack", r),  o_ack,  tbl[r].ack);
      chk($sformatf("tbl%0d_busy", r), o_busy, tbl[r].busy);
      chk($sformatf("tbl%0d_wrap", r), o_wrap, tbl[r].wrap);
      if (tbl[r].use_count)
        chk($sformatf("tbl%0d_count", r), o_count, tbl[r].count);
    end
    i_req = '0;
    i_clr = '0;

    // Wrap, with a clear during S_OPERAND masking the first wrap.
    do_reset();
    incr(2, a, wr);
    chk("first_inc_wrap", wr, 0);
    for (int n = 1; n < 255; n++) incr(2, a, wr);
    chk("preload_ff", cnt(2), 8'hFF);
    i_req = 4'b0100;
    @(negedge i_clk);
    i_clr = 4'b0100;
    @(negedge i_clk);
    i_clr = '0;
    chk("opclr_wrap_ack",    o_ack,  4'b0100);
    chk("opclr_wrap_masked", o_wrap, 0);
    i_req = '0;
    @(negedge i_clk);
    chk("opclr_wrap_count", cnt(2), 8'h00);
    for (int n = 0; n < 255; n++) incr(2, a, wr);
    chk("repreload_ff", cnt(2), 8'hFF);
    incr(2, a, wr);
    chk("wrap_ack",   a,      4'b0100);
    chk("wrap_pulse", wr,     1);
    chk("wrap_after", o_wrap, 0);
    chk("wrap_count", cnt(2), 8'h00);

    // Clear of channel 1 at 0x10 during S_WRITE.
    do_reset();
    for (int n = 0; n < 16; n++) incr(1, a, wr);
    chk("ch1_preload", cnt(1), 8'h10);
    i_req = 4'b0010;
    @(negedge i_clk);
    chk("wclr_operand_busy", o_busy, 1);
    @(negedge i_clk);
    chk("wclr_ack",  o_ack,  4'b0010);
    chk("wclr_wrap", o_wrap, 0);
    i_clr = 4'b0010;
    i_req = '0;
    @(negedge i_clk);
    i_clr = '0;
    chk("wclr_count", cnt(1), 8'h00);

    // Clear during S_OPERAND cancels write-back.
    for (int n = 0; n < 16; n++) incr(1, a, wr);
    i_req = 4'b0010;
    @(negedge i_clk);
    i_clr = 4'b0010;
    @(negedge i_clk);
    i_clr = '0;
    chk("oclr_ack", o_ack, 4'b0010);
    i_req = '0;
    @(negedge i_clk);
    chk("oclr_count", cnt(1), 8'h00);

    // Clear in the S_IDLE grant cycle: operand already latched, stores old+1.
    for (int n = 0; n < 16; n++) incr(1, a, wr);
    i_req = 4'b0010;
    i_clr = 4'b0010;
    @(negedge i_clr[1] ? i_clk : i_clk);
    i_clr = '0;
    chk("gclr_cleared", cnt(1), 8'h00);
    @(negedge i_clk);
    chk("gclr_ack", o_ack, 4'b0010);
    i_req = '0;
    @(negedge i_clk);
    chk("gclr_count", cnt(1), 8'h11);

    // Asynchronous reset during S_OPERAND for channel 3.
    do_reset();
    incr(0, a, wr);
    incr(3, a, wr);
    chk("pre_reset_counts", o_count, 32'h01000001);
    i_req = 4'b1000;
    @(negedge i_clk);
    chk("midop_busy", o_busy, 1);
    i_RESET_n = 1'b0;
    #1;
    chk("midop_reset_busy",  o_busy,  0);
    chk("midop_reset_ack",   o_ack,   0);
    chk("midop_reset_count", o_count, 0);
    @(negedge i_clk);
    i_req     = '0;
    i_RESET_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge i_clk);
      chk($sformatf("post_reset%0d_ack", n),  o_ack,  0);
      chk($sformatf("post_reset%0d_busy", n), o_busy, 0);
    end

    // Request withdrawn right after grant still completes, once.
    i_req = 4'b1000;
    @(negedge i_clk);
    i_req = '0;
    chk("withdraw_busy", o_busy, 1);
    @(negedge i_clk);
    chk("withdraw_ack", o_ack, 4'b1000);
    @(negedge i_clk);
    chk("withdraw_count", o_count, 32'h01000000);
    for (int n = 0; n < 3; n++) begin
      @(negedge i_clk);
      chk($sformatf("withdraw_idle%0d_busy", n), o_busy, 0);
      chk($sformatf("withdraw_idle%0d_ack", n),  o_ack,  0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
